// File: rtl/sonar_ping_sequencer.sv
// sonar_ping_sequencer: sequences each sonar ping (burst, blank, listen, report) and captures debounced echo arrival times.
// Latency: outputs are registered; the result bundle loads and result_valid_out pulses on the last cycle of each ping.
// Backpressure: none. Samples are qualified by sample_valid_in. Optional macro ECHO_PEAK_EN adds per-echo peak capture.
module sonar_ping_sequencer #(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int MAX_ECHOES    = 4,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int TIME_WIDTH    = 24,
  parameter int DEBOUNCE      = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               enable_in,
  input  logic [SAMPLE_WIDTH-1:0]            threshold_in,
  input  logic [SAMPLE_WIDTH-1:0]            hysteresis_in,
  input  logic [SAMPLE_WIDTH-1:0]            sample_in,
  input  logic                               sample_valid_in,
  output logic                               burst_start_out,
  output logic                               burst_active_out,
  output logic                               listen_out,
  output logic [TIME_WIDTH-1:0]              time_out,
  output logic                               result_valid_out,
  output logic [$clog2(MAX_ECHOES+1)-1:0]    echo_count_out,
  output logic [MAX_ECHOES*TIME_WIDTH-1:0]   echo_time_out,
  output logic [MAX_ECHOES*SAMPLE_WIDTH-1:0] echo_peak_out,
  output logic                               no_echo_out,
  output logic                               busy_out
);

  localparam int CW = $clog2(MAX_ECHOES+1);
  localparam int RW = $clog2(DEBOUNCE+1);
  localparam int SW = SAMPLE_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BURST  = 3'd1;
  localparam logic [2:0] S_BLANK  = 3'd2;
  localparam logic [2:0] S_LISTEN = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [TIME_WIDTH-1:0] T_BLANK_START  = TIME_WIDTH'(BURST_CYCLES);
  localparam logic [TIME_WIDTH-1:0] T_LISTEN_START = TIME_WIDTH'(BURST_CYCLES + BLANK_CYCLES);
  localparam logic [TIME_WIDTH-1:0] T_REPORT       = TIME_WIDTH'(PERIOD_CYCLES - 1);
  localparam logic [RW-1:0]         DEB_LAST       = RW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]         MAX_CNT        = CW'(MAX_ECHOES);

  // Sequencer state and timebase
  logic [2:0]            r_state, w_nxt_state;
  logic [TIME_WIDTH-1:0] r_t, w_nxt_t;
  logic                  w_start;

  // Echo detector scratch
  logic                            r_armed;
  logic [RW-1:0]                   r_run;
  logic [TIME_WIDTH-1:0]           r_cand;
  logic [CW-1:0]                   r_count;
  logic [MAX_ECHOES*TIME_WIDTH-1:0] r_times;
  logic [MAX_ECHOES*TIME_WIDTH-1:0] w_slot_times, w_scr_times;
  logic [CW-1:0]                   w_nxt_count;
  logic [TIME_WIDTH-1:0]           w_cand;
  logic [SAMPLE_WIDTH-1:0]         w_rearm_lvl;
  logic                            w_above, w_listen_vld, w_hit, w_qual, w_store;

  // Registered outputs
  logic                             r_burst_start, r_burst_active, r_listen, r_busy;
  logic                             r_result_valid, r_no_echo;
  logic [CW-1:0]                    r_echo_count;
  logic [MAX_ECHOES*TIME_WIDTH-1:0] r_echo_time;

  // Next state and timebase; a new ping starts from IDLE or straight out of REPORT
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_t     = r_t;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE, S_REPORT: begin
        w_nxt_t = '0;
        if (enable_in) begin
          w_nxt_state = S_BURST;
          w_start     = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      default: begin
        w_nxt_t = r_t + 1'b1;
        if (w_nxt_t < T_BLANK_START)       w_nxt_state = S_BURST;
        else if (w_nxt_t < T_LISTEN_START) w_nxt_state = S_BLANK;
        else if (w_nxt_t == T_REPORT)      w_nxt_state = S_REPORT;
        else                               w_nxt_state = S_LISTEN;
      end
    endcase
  end

  // Re-arm level saturates at zero when hysteresis exceeds the threshold
  assign w_rearm_lvl  = (threshold_in > hysteresis_in) ? (threshold_in - hysteresis_in) : '0;
  assign w_above      = (sample_in >= threshold_in);
  assign w_listen_vld = (r_state == S_LISTEN) && sample_valid_in;
  assign w_hit        = w_listen_vld && w_above && r_armed;
  assign w_qual       = w_hit && (r_run == DEB_LAST);
  assign w_store      = w_qual && (r_count < MAX_CNT);
  assign w_cand       = (r_run == '0) ? r_t : r_cand;
  assign w_nxt_count  = w_store ? (r_count + 1'b1) : r_count;
  assign w_scr_times  = w_store ? w_slot_times : r_times;

  // Slot image with the candidate time written into the next free slot
  always_comb begin
    w_slot_times = r_times;
    for (int i = 0; i < MAX_ECHOES; i++) begin
      if (CW'(i) == r_count) w_slot_times[i*TIME_WIDTH +: TIME_WIDTH] = w_cand;
    end
  end

  // Echo detector: arm below the re-arm level, debounce above threshold, record qualified echoes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_armed <= 1'b0;
      r_run   <= '0;
      r_cand  <= '0;
      r_count <= '0;
      r_times <= '0;
    end else if (w_start) begin
      r_armed <= 1'b0;
      r_run   <= '0;
      r_cand  <= '0;
      r_count <= '0;
      r_times <= '0;
    end else begin
      if (r_state == S_BURST && w_nxt_state != S_BURST) begin
        r_armed <= 1'b0;
      end else if (w_qual) begin
        r_armed <= 1'b0;
      end else if ((r_state == S_BLANK || r_state == S_LISTEN) && sample_valid_in &&
                   (sample_in < w_rearm_lvl)) begin
        r_armed <= 1'b1;
      end

      // A run left open when LISTEN ends is simply dropped
      if (r_state != S_LISTEN) begin
        r_run <= '0;
      end else if (sample_valid_in) begin
        if (!w_above || w_qual) r_run <= '0;
        else if (r_armed)       r_run <= r_run + 1'b1;
      end

      if (w_hit && r_run == '0) r_cand <= r_t;

      // Echoes past MAX_ECHOES qualify (and disarm) but are not recorded
      r_count <= w_nxt_count;
      r_times <= w_scr_times;
    end
  end

  // Output registers; the result bundle takes the scratch image including the final LISTEN sample
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= S_IDLE;
      r_t            <= '0;
      r_burst_start  <= 1'b0;
      r_burst_active <= 1'b0;
      r_listen       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_echo_count   <= '0;
      r_echo_time    <= '0;
      r_no_echo      <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_t            <= w_nxt_t;
      r_burst_start  <= w_start;
      r_burst_active <= (w_nxt_state == S_BURST);
      r_listen       <= (w_nxt_state == S_LISTEN);
      r_busy         <= (w_nxt_state != S_IDLE);
      r_result_valid <= (w_nxt_state == S_REPORT);
      if (w_nxt_state == S_REPORT) begin
        r_echo_count <= w_nxt_count;
        r_echo_time  <= w_scr_times;
        r_no_echo    <= (w_nxt_count == '0);
      end
    end
  end

`ifdef ECHO_PEAK_EN
  logic [MAX_ECHOES*SW-1:0] r_peaks, w_scr_peaks, r_echo_peak;
  logic [SW-1:0]            r_run_pk, w_run_pk;
  logic                     r_trk;
  logic [CW-1:0]            r_trk_slot;

  assign w_run_pk = ((r_run == '0) || (sample_in > r_run_pk)) ? sample_in : r_run_pk;

  // Peak image: seed a slot from the qualifying run, then keep raising it while the echo stays above threshold
  always_comb begin
    w_scr_peaks = r_peaks;
    for (int i = 0; i < MAX_ECHOES; i++) begin
      if (w_store && CW'(i) == r_count) w_scr_peaks[i*SW +: SW] = w_run_pk;
      if (r_trk && w_listen_vld && w_above && CW'(i) == r_trk_slot &&
          sample_in > r_peaks[i*SW +: SW]) begin
        w_scr_peaks[i*SW +: SW] = sample_in;
      end
    end
  end

  // Peak tracking registers and the published peak bundle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_peaks     <= '0;
      r_run_pk    <= '0;
      r_trk       <= 1'b0;
      r_trk_slot  <= '0;
      r_echo_peak <= '0;
    end else begin
      if (w_start) begin
        r_peaks  <= '0;
        r_run_pk <= '0;
        r_trk    <= 1'b0;
      end else begin
        r_peaks <= w_scr_peaks;
        if (w_hit) r_run_pk <= w_run_pk;
        if (w_store) begin
          r_trk      <= 1'b1;
          r_trk_slot <= r_count;
        end else if (r_state != S_LISTEN || (sample_valid_in && !w_above)) begin
          r_trk <= 1'b0;
        end
      end
      if (w_nxt_state == S_REPORT) r_echo_peak <= w_scr_peaks;
    end
  end

  assign echo_peak_out = r_echo_peak;
`else
  assign echo_peak_out = '0;
`endif

  assign burst_start_out  = r_burst_start;
  assign burst_active_out = r_burst_active;
  assign listen_out       = r_listen;
  assign time_out         = r_t;
  assign result_valid_out = r_result_valid;
  assign echo_count_out   = r_echo_count;
  assign echo_time_out    = r_echo_time;
  assign no_echo_out      = r_no_echo;
  assign busy_out         = r_busy;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Directed bench for sonar_ping_sequencer with a 64-cycle ping.
// Inputs change 1 time unit after each rising edge; outputs are read at the same point.
// Expected values are hand-computed from the ping schedule and the stimulus patterns.
module tb_sonar_ping_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [15:0] threshold_in = 16'd100;
  logic [15:0] hysteresis_in = 16'd10;
  logic [15:0] sample_in = 16'd0;
  logic        sample_valid_in = 1'b1;
  logic        burst_start_out, burst_active_out, listen_out, result_valid_out;
  logic        no_echo_out, busy_out;
  logic [7:0]  time_out;
  logic [1:0]  echo_count_out;
  logic [15:0] echo_time_out;
  logic [31:0] echo_peak_out;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sonar_ping_sequencer #(
    .PERIOD_CYCLES(64), .BURST_CYCLES(8), .BLANK_CYCLES(4), .MAX_ECHOES(2),
    .SAMPLE_WIDTH(16), .TIME_WIDTH(8), .DEBOUNCE(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .threshold_in(threshold_in), .hysteresis_in(hysteresis_in),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .burst_start_out(burst_start_out), .burst_active_out(burst_active_out),
    .listen_out(listen_out), .time_out(time_out), .result_valid_out(result_valid_out),
    .echo_count_out(echo_count_out), .echo_time_out(echo_time_out),
    .echo_peak_out(echo_peak_out), .no_echo_out(no_echo_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat_val(input int pat, input int t);
    logic [15:0] v;
    v = 16'd0;
    case (pat)
      2: if (t >= 5 && t <= 11) v = 16'd200;
      3: if ((t >= 20 && t <= 22) || t == 30) v = 16'd200;
      4: begin
        if (t == 20 || t == 25 || t == 26 || t == 40 || t == 41 || t == 50 || t == 51) v = 16'd200;
        if (t == 21) v = 16'd250;
        if (t >= 22 && t <= 24) v = 16'd95;
        if (t == 30 || t == 45) v = 16'd80;
      end
      6: if (t == 20 || t == 21) v = 16'd200;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Walks one ping from t=0 to last_t, checking the timing outputs each cycle
  task automatic run_ping(input int pat, input int drop_at, input int last_t);
    for (int t = 0; t <= last_t; t++) begin
      chk("time", 64'(time_out), 64'(t));
      chk("burst_start", 64'(burst_start_out), 64'(t == 0));
      chk("burst_active", 64'(burst_active_out), 64'(t < 8));
      chk("listen", 64'(listen_out), 64'(t >= 12 && t <= 62));
      chk("result_valid", 64'(result_valid_out), 64'(t == 63));
      chk("busy", 64'(busy_out), 64'(1));
      sample_in = pat_val(pat, t);
      if (t == drop_at) enable_in = 1'b0;
      tick();
    end
  endtask

  task automatic chk_res(input string tag, input int cnt, input logic [15:0] times,
                         input logic [31:0] peaks, input logic no_echo);
    chk({tag, "_count"}, 64'(echo_count_out), 64'(cnt));
    chk({tag, "_times"}, 64'(echo_time_out), 64'(times));
`ifdef ECHO_PEAK_EN
    chk({tag, "_peaks"}, 64'(echo_peak_out), 64'(peaks));
`else
    chk({tag, "_peaks"}, 64'(echo_peak_out), 64'(peaks & 32'h0));
`endif
    chk({tag, "_no_echo"}, 64'(no_echo_out), 64'(no_echo));
  endtask

  initial begin
    logic rv_seen;
    logic busy_seen;

    // Reset state
    tick(); tick(); tick();
    chk("rst_busy", 64'(busy_out), 64'(0));
    chk("rst_time", 64'(time_out), 64'(0));
    chk("rst_burst_start", 64'(burst_start_out), 64'(0));
    chk("rst_burst_active", 64'(burst_active_out), 64'(0));
    chk("rst_listen", 64'(listen_out), 64'(0));
    chk("rst_result_valid", 64'(result_valid_out), 64'(0));
    chk_res("rst", 0, 16'h0000, 32'h0, 1'b0);

    // Ping 1: baseline only; start on the cycle after enable is sampled
    rst_in = 1'b0;
    enable_in = 1'b1;
    tick();
    run_ping(0, -1, 63);
    chk_res("ping1", 0, 16'h0000, 32'h0, 1'b1);
    chk("ping2_start", 64'(burst_start_out), 64'(1));

    // Ping 2: strong samples only during burst/blank
    run_ping(2, -1, 63);
    chk_res("blank", 0, 16'h0000, 32'h0, 1'b1);

    // Ping 3: one debounced echo at 20, single-cycle spike at 30 ignored
    run_ping(3, -1, 63);
    chk_res("single", 1, 16'h0014, 32'h0000_00C8, 1'b0);

    // Ping 4: hysteresis blocks the 25..26 burst, slot1 at 40, third echo dropped
    run_ping(4, -1, 63);
    chk_res("hyst", 2, 16'h2814, 32'h00C8_00FA, 1'b0);

    // Ping 5: enable drops at t=30, ping still completes then goes idle
    run_ping(3, 30, 63);
    chk_res("enable_drop", 1, 16'h0014, 32'h0000_00C8, 1'b0);
    chk("idle_busy", 64'(busy_out), 64'(0));
    chk("idle_burst_start", 64'(burst_start_out), 64'(0));
    chk("idle_time", 64'(time_out), 64'(0));
    tick();
    chk("idle_hold_busy", 64'(busy_out), 64'(0));
    chk("idle_hold_burst_active", 64'(burst_active_out), 64'(0));

    // Ping 6: echo qualifies at 21, then reset at t=25 aborts the ping
    enable_in = 1'b1;
    tick();
    run_ping(6, -1, 24);
    chk("pre_rst_time", 64'(time_out), 64'(25));
    rst_in = 1'b1;
    enable_in = 1'b0;
    sample_in = 16'd0;
    tick();
    rv_seen = result_valid_out;
    busy_seen = busy_out;
    chk("abort_time", 64'(time_out), 64'(0));
    chk("abort_listen", 64'(listen_out), 64'(0));
    chk("abort_burst_active", 64'(burst_active_out), 64'(0));
    chk_res("abort", 0, 16'h0000, 32'h0, 1'b0);
    rst_in = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      rv_seen = rv_seen | result_valid_out;
      busy_seen = busy_seen | busy_out;
    end
    chk("abort_no_result_valid", 64'(rv_seen), 64'(0));
    chk("abort_stays_idle", 64'(busy_seen), 64'(0));
    chk_res("abort_hold", 0, 16'h0000, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sonar_ping_sequencer.md
Name: sonar_ping_sequencer

Overview:
- Parametrised successor to the fixed pwm/evt_counter ping timing in the sonar top level.
- Sequences one sonar ping per period: transmit burst, blanking window, then a listen window.
- During the listen window it captures up to MAX_ECHOES echo arrival times from the aggregated receive waveform. Detection uses a threshold with hysteresis and debounce.
- Publishes a per-ping result bundle for time_of_flight, velocity and the display path.

Parameters:
- PERIOD_CYCLES, 16777216, total ping period in clk_in cycles.
- BURST_CYCLES, 524288, transmit burst length.
- BLANK_CYCLES, 65536, post-burst ringing blanking length.
- MAX_ECHOES, 4, maximum echoes recorded per ping (≥1).
- SAMPLE_WIDTH, 16, receive sample width (unsigned magnitude).
- TIME_WIDTH, 24, timestamp width; must hold PERIOD_CYCLES-1.
- DEBOUNCE, 4, consecutive valid above-threshold samples required to qualify an echo (≥1).
- Legal range: BURST_CYCLES+BLANK_CYCLES ≤ PERIOD_CYCLES-2.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- enable_in  in  1  run pings continuously while high
- threshold_in  in  SAMPLE_WIDTH  echo detect level
- hysteresis_in  in  SAMPLE_WIDTH  re-arm margin below threshold
- sample_in  in  SAMPLE_WIDTH  aggregated waveform sample
- sample_valid_in  in  1  sample_in qualifier
- burst_start_out  out  1  one-cycle pulse on the first burst cycle
- burst_active_out  out  1  gates transmitter drive
- listen_out  out  1  high during the listen window
- time_out  out  TIME_WIDTH  cycles since the current burst start
- result_valid_out  out  1  one-cycle pulse when the result registers update
- echo_count_out  out  $clog2(MAX_ECHOES+1)  echoes captured in the last ping
- echo_time_out  out  MAX_ECHOES*TIME_WIDTH  packed echo times; echo 0 in the LSBs; unused slots 0
- echo_peak_out  out  MAX_ECHOES*SAMPLE_WIDTH  packed echo peaks (see Optional Feature)
- no_echo_out  out  1  last ping captured zero echoes
- busy_out  out  1  state ≠ IDLE

Behaviour:
- Reset: state IDLE, t=0, every output 0, armed=0, run counter 0, echo scratch cleared. Reset mid-ping aborts immediately; no result_valid_out is emitted for the aborted ping.
- States: IDLE, BURST, BLANK, LISTEN, REPORT. All outputs are registered.
- IDLE→BURST: the cycle after enable_in is sampled high. In the first BURST cycle: t=0, burst_start_out=1, scratch echo count/times/peaks cleared.
- t increments every cycle outside IDLE.
- BURST while t<BURST_CYCLES.
- BLANK while t<BURST_CYCLES+BLANK_CYCLES.
- LISTEN through t=PERIOD_CYCLES-2.
- REPORT at t=PERIOD_CYCLES-1: result registers load from scratch, result_valid_out=1.
- After REPORT: to BURST with t=0 if enable_in=1, else to IDLE.
- enable_in deasserting mid-ping does not truncate the ping.
- burst_active_out = (state==BURST); listen_out = (state==LISTEN).
- Armed flag:
  - Cleared on BLANK entry.
  - Set on any valid sample with sample_in < sat0(threshold_in-hysteresis_in), in BLANK or LISTEN.
  - Cleared when an echo qualifies.
- Run counter:
  - In LISTEN with armed=1, a valid sample ≥ threshold_in increments the run.
  - The first sample of a run latches t as the candidate time.
  - A valid sample below threshold_in resets the run.
  - Invalid cycles hold the run unchanged.
  - Run reaching DEBOUNCE: if count<MAX_ECHOES, store the candidate time in slot[count] and increment count. If count==MAX_ECHOES, discard silently.
  - An echo qualifies only while armed=1, so after each echo the detector must re-arm before the next one can qualify.
- A run still open at LISTEN exit is discarded.
- Samples in BURST/BLANK/REPORT/IDLE never create echoes.
- Result registers hold between REPORT cycles; no_echo_out = (count==0), loaded at REPORT.
- Subtraction saturates at 0. Comparisons are unsigned.

Optional Feature:
- Macro ECHO_PEAK_EN.
- Defined: per slot, track the maximum sample_in over the qualifying run and continue tracking while above threshold until the next below-threshold valid sample. Load into echo_peak_out at REPORT.
- Undefined: echo_peak_out is tied to 0 and no peak logic is built. The port is always present.

Test Plan:
Parameters for all tests: PERIOD_CYCLES=64, BURST=8, BLANK=4, MAX_ECHOES=2, DEBOUNCE=2, TIME_WIDTH=8, threshold=100, hysteresis=10, sample valid every cycle, baseline sample 0.
1. Ping timing: release reset, enable_in=1 → burst_start_out pulse at t=0; burst_active_out t=0..7; listen_out t=12..62; result_valid_out at t=63; next burst_start_out 1 cycle later.
2. Blanking: sample=200 at t=5..11 only → no_echo_out=1, echo_count_out=0.
3. Single echo and debounce: sample=200 at t=20..22 → echo_time slot0=20, count=1. A one-cycle spike of 200 at t=30 adds no echo.
4. Hysteresis: 200 at t=20..21, then 95 at t=22..24, then 200 at t=25..26 → one echo only. Then 80 at t=30, 200 at t=40..41 → slot1=40. Further 80 at t=45, 200 at t=50..51 → discarded; count=2. With ECHO_PEAK_EN and a 250 sample at t=21, slot0 peak=250.
5. Enable drop: enable_in→0 at t=30 → ping completes, result_valid_out at t=63, then IDLE with busy_out=0.
6. Reset mid-listen: rst_in at t=25 after a qualified echo → next cycle all outputs 0, IDLE, no result_valid_out pulse.
